// File: rtl/q3b_pkg.sv
// Shared types for the q3b serial transmitter and its downstream detector mirror.
package q3b_pkg;

  typedef enum logic [2:0] {TxIdle, TxStart, TxData, TxParity, TxStop} tx_state_t;
  typedef enum logic [2:0] {DetA, DetB, DetC, DetD, DetE} det_state_t;

  localparam logic StartBit = 1'b1;
  localparam logic StopBit  = 1'b0;

  function automatic det_state_t det_next(det_state_t s, logic x);
    det_state_t n;
    case (s)
      DetA:    n = x ? DetB : DetA;
      DetB:    n = x ? DetE : DetB;
      DetC:    n = x ? DetB : DetC;
      DetD:    n = x ? DetC : DetB;
      DetE:    n = x ? DetE : DetD;
      default: n = DetA;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/q3b_serial_tx_if.sv
// Upstream valid/ready word channel into the q3b serial transmitter.
interface q3b_serial_tx_if #(
  parameter int unsigned DATA_W = 8
) ();
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;

  modport master (output in_valid, output in_data, input in_ready);
  modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/q3b_det_model.sv
// Cycle-exact mirror of the downstream 5-state Moore detector; z high in D/E.
module q3b_det_model
  import q3b_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic x_i,
  output logic z_o
);

  det_state_t st_q, st_d;
  logic       z_q;

  always_comb st_d = det_next(st_q, x_i);

  // z is registered from the next state so it tracks the detector's own Moore output.
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= DetA;
      z_q  <= 1'b0;
    end else begin
      st_q <= st_d;
      z_q  <= (st_d == DetD) || (st_d == DetE);
    end
  end

  assign z_o = z_q;

endmodule

// File: rtl/q3b_serial_tx.sv
// Serial frame transmitter: start, DATA_W bits LSB first, optional even parity
// (Q3B_SERIAL_TX_PARITY_EN), stop; plus a mirror of the downstream detector.
module q3b_serial_tx
  import q3b_pkg::*;
#(
  parameter int unsigned DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  q3b_serial_tx_if.slave        in_if,
  output logic                  x_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  z_pred_o
);

  localparam int unsigned    CntW    = $clog2(DATA_W + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(DATA_W - 1);

  tx_state_t         state_q;
  logic [DATA_W-1:0] shift_q, shift_nx;
  logic [CntW-1:0]   cnt_q;
  logic              x_q, done_q, hs;
`ifdef Q3B_SERIAL_TX_PARITY_EN
  logic              par_q;
`endif

  assign in_if.in_ready = (state_q == TxIdle) || (state_q == TxStop);
  assign hs             = in_if.in_valid && in_if.in_ready;
  assign shift_nx       = shift_q >> 1;

  // x_q holds the line value for the cycle that follows each edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= TxIdle;
      shift_q <= '0;
      cnt_q   <= '0;
      x_q     <= 1'b0;
      done_q  <= 1'b0;
`ifdef Q3B_SERIAL_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        TxIdle, TxStop: begin
          done_q  <= (state_q == TxStop);
          state_q <= TxIdle;
          x_q     <= StopBit;
          if (hs) begin
            shift_q <= in_if.in_data;
`ifdef Q3B_SERIAL_TX_PARITY_EN
            par_q   <= ^in_if.in_data;
`endif
            state_q <= TxStart;
            x_q     <= StartBit;
          end
        end
        TxStart: begin
          state_q <= TxData;
          cnt_q   <= '0;
          x_q     <= shift_q[0];
        end
        TxData: begin
          if (cnt_q == CntLast) begin
`ifdef Q3B_SERIAL_TX_PARITY_EN
            state_q <= TxParity;
            x_q     <= par_q;
`else
            state_q <= TxStop;
            x_q     <= StopBit;
`endif
          end else begin
            cnt_q   <= cnt_q + 1'b1;
            shift_q <= shift_nx;
            x_q     <= shift_nx[0];
          end
        end
        TxParity: begin
          state_q <= TxStop;
          x_q     <= StopBit;
        end
        default: begin
          state_q <= TxIdle;
          x_q     <= StopBit;
        end
      endcase
    end
  end

  q3b_det_model u_det (
    .clk   (clk),
    .reset (reset),
    .x_i   (x_q),
    .z_o   (z_pred_o)
  );

  assign x_o    = x_q;
  assign busy_o = (state_q != TxIdle);
  assign done_o = done_q;

endmodule

// File: doc/q3b_serial_tx.md
# q3b_serial_tx

Serial frame transmitter that drives the single-bit `x` line consumed by the team's 5-state Moore detector (states A–E, `z` high in D/E). It accepts parallel words over a valid/ready handshake and shifts them out one bit per clock. It also runs a cycle-exact mirror of the downstream detector, so upstream logic can see the receiver's `z` without a return path.

## Interface
- `DATA_W`, default 8: payload bits per frame, ≥ 1.
- `clk`  in  1: clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-high.
- `in_valid`  in  1: upstream word available.
- `in_data`  in  DATA_W: word to transmit, sampled on the handshake.
- `in_ready`  out  1: block can accept a word this cycle.
- `x`  out  1: registered serial line to the detector.
- `busy`  out  1: a frame is in flight (state ≠ IDLE).
- `done`  out  1: one-cycle pulse in the cycle after the stop bit.
- `z_pred`  out  1: mirrored detector output, registered.

## Operation
- Transmit FSM states: IDLE, START, DATA, PARITY, STOP.
- IDLE: `x`=0. A handshake (`in_valid`&&`in_ready` at an edge) latches `in_data` into the shift register and moves to START.
- START: `x`=1 for 1 cycle.
- DATA: `x` = shift[0], LSB first, for DATA_W cycles. A bit counter of width clog2(DATA_W+1) counts up to DATA_W−1.
- PARITY: present only when the macro is defined. See Configuration.
- STOP: `x`=0 for 1 cycle, then IDLE. If a handshake occurs in this cycle, the next state is START instead (back-to-back frames, no idle gap).
- `in_ready` = (state==IDLE || state==STOP), combinational from state.
- `done` is registered and asserts for exactly one cycle after the STOP cycle, including on a back-to-back transition.
- Mirror FSM (states A–E) updates every edge using the current `x`:
  - A: 1→B, 0→A.
  - B: 1→E, 0→B.
  - C: 1→B, 0→C.
  - D: 1→C, 0→B.
  - E: 1→E, 0→D.
- `z_pred` = (mirror ∈ {D, E}).
- Reset, including mid-frame: transmit FSM→IDLE, mirror→A, `x`=0, `done`=0, `busy`=0, `z_pred`=0, shift register and counter cleared. A handshake in the reset cycle is ignored.

## Timing
- Handshake at edge N: `x`=start bit during cycle N+1. Payload bit i appears during cycle N+2+i.
- STOP occupies cycle N+2+DATA_W, or N+3+DATA_W with parity.
- Frame length is DATA_W+2 cycles, or DATA_W+3 with parity.
- `in_ready` is 0 from START through the last DATA/PARITY cycle. `in_data` is ignored there.
- The mirror lags `x` by one edge: `z_pred` in cycle k reflects `x` up to cycle k−1. This matches the detector's own timing.
- `in_valid` held with `in_ready`=0: no effect, no error.

## Configuration
- Macro: `Q3B_SERIAL_TX_PARITY_EN`.
- Defined: PARITY state inserted between DATA and STOP, driving `x` = XOR of all payload bits (even parity) for 1 cycle. Frame length becomes DATA_W+3.
- Undefined: DATA goes directly to STOP. No parity logic is generated.

## Structure
- Shared package `q3b_pkg` holds:
  - `tx_state_t` enum: IDLE, START, DATA, PARITY, STOP.
  - `det_state_t` enum: A, B, C, D, E.
  - Localparams for the start bit value (1) and stop bit value (0).
- Sub-module `q3b_det_model`: the mirror FSM (clk, reset, x → z). Verification reuses it as the scoreboard reference for the real detector.

## Test plan
- Reset, then `in_valid`=0 for 5 cycles → `x`=0, `in_ready`=1, `busy`=0, `z_pred`=0 throughout.
- Send 0xA5, parity disabled → `x` = 1,1,0,1,0,0,1,0,1,0 over 10 cycles. `done` pulses once. Mirror ends in D, so `z_pred`=1 in the cycle after STOP.
- Send 0xA5 then 0x0F with `in_valid` held → second start bit immediately follows the STOP cycle. Total 20 cycles, `done` pulses twice.
- Parity enabled, send 0x07 → parity bit 1, frame length 11. Send 0xA5 → parity bit 0.
- Assert reset during DATA bit 3 → next cycle `x`=0, `busy`=0, `z_pred`=0, no `done`. A fresh 0x01 then transmits correctly.
- Hold `in_valid`=1 and change `in_data` mid-frame → transmitted bits match the word latched at the handshake only.
